// File: rtl/intpol2_d4_control.sv
// Control FSM for a 4-phase (x4) quadratic interpolator: fills three samples,
// then for every coefficient set sequences four multiply/accumulate phases.
module intpol2_d4_control #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] data_to_process,
    output logic                         Ld_M0,
    output logic                         Ld_M1,
    output logic                         Ld_M2,
    output logic                         en_stream,
    output logic                         op_1,
    output logic                         clear,
    output logic                         en_sum,
    output logic                         sel_mult,
    output logic                         Ld_p1_xi,
    output logic                         Ld_data,
    output logic [1:0]                   sel_xi2,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    typedef enum logic [2:0] {IDLE, FILL, COEF, MUL1, MUL2, SHIFT} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] smp_cnt;
    logic [1:0]           phase;
    logic                 err_q;
    logic                 out_valid_q;
    logic                 accept;
    logic                 last_seg;

    assign data_to_process = in_data;
    assign accept          = in_valid & in_ready;
    // smp_cnt counts every sample taken so far, including the three fill samples
    assign last_seg        = (smp_cnt == len_q);
    assign busy            = (state != IDLE);
    assign err             = err_q;
    assign out_valid       = out_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            smp_cnt     <= '0;
            phase       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            err_q       <= 1'b0;
            out_valid_q <= Ld_data;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_len >= LEN_WIDTH'(3)) begin
                            len_q   <= cfg_len;
                            smp_cnt <= '0;
                            phase   <= '0;
                            state   <= FILL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        smp_cnt <= smp_cnt + LEN_WIDTH'(1);
                        if (smp_cnt == LEN_WIDTH'(2)) state <= COEF;
                    end
                end
                COEF: begin
                    phase <= '0;
                    state <= MUL1;
                end
                MUL1: state <= MUL2;
                MUL2: begin
                    if (out_ready) begin
                        phase <= phase + 2'd1;
                        if (phase != 2'd3)  state <= MUL1;
                        else if (last_seg)  state <= IDLE;
                        else                state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        smp_cnt <= smp_cnt + LEN_WIDTH'(1);
                        state   <= COEF;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from the registered state so they line up with the
    // handshake cycle; reset forces IDLE, which drives them all low.
    always_comb begin
        in_ready  = 1'b0;
        Ld_M0     = 1'b0;
        Ld_M1     = 1'b0;
        Ld_M2     = 1'b0;
        en_stream = 1'b0;
        op_1      = 1'b0;
        clear     = 1'b0;
        en_sum    = 1'b0;
        sel_mult  = 1'b0;
        Ld_p1_xi  = 1'b0;
        Ld_data   = 1'b0;
        sel_xi2   = 2'd0;
        done      = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                Ld_M0    = in_valid && (smp_cnt == LEN_WIDTH'(0));
                Ld_M1    = in_valid && (smp_cnt == LEN_WIDTH'(1));
                Ld_M2    = in_valid && (smp_cnt == LEN_WIDTH'(2));
            end
            COEF: begin
                op_1  = 1'b1;
                clear = 1'b1;
            end
            MUL1: begin
                Ld_p1_xi = 1'b1;
                sel_xi2  = phase;
            end
            MUL2: begin
                sel_xi2 = phase;
                if (out_ready) begin
                    sel_mult = 1'b1;
                    Ld_data  = 1'b1;
                    en_sum   = 1'b1;
                    done     = (phase == 2'd3) && last_seg;
                end
            end
            SHIFT: begin
                in_ready  = 1'b1;
                en_stream = in_valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intpol2_d4_control.sv
// Directed bench for intpol2_d4_control: a per-cycle vector table for the
// basic frame plus hand-written sequences for stalls, waits, errors and reset.
module tb_intpol2_d4_control;

    localparam int DW = 32;
    localparam int LW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LW-1:0]        cfg_len;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 out_ready;
    logic                 out_valid;
    logic signed [DW-1:0] data_to_process;
    logic Ld_M0, Ld_M1, Ld_M2, en_stream, op_1, clear, en_sum, sel_mult;
    logic Ld_p1_xi, Ld_data, busy, done, err;
    logic [1:0]           sel_xi2;

    intpol2_d4_control #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid),
        .data_to_process(data_to_process),
        .Ld_M0(Ld_M0), .Ld_M1(Ld_M1), .Ld_M2(Ld_M2), .en_stream(en_stream),
        .op_1(op_1), .clear(clear), .en_sum(en_sum), .sel_mult(sel_mult),
        .Ld_p1_xi(Ld_p1_xi), .Ld_data(Ld_data), .sel_xi2(sel_xi2),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Field order: ldm{M2,M1,M0} op1 clr smul p1 ld es sx est ir ov bz dn er
    typedef struct packed {
        logic [2:0] ldm;
        logic op1, clr, smul, p1, ld, es;
        logic [1:0] sx;
        logic est, ir, ov, bz, dn, er;
    } obs_t;

    typedef struct {
        logic st;
        logic iv;
        logic ordy;
        obs_t exp;
    } vec_t;

    obs_t obs;
    always_comb obs = {Ld_M2, Ld_M1, Ld_M0, op_1, clear, sel_mult, Ld_p1_xi,
                       Ld_data, en_sum, sel_xi2, en_stream, in_ready,
                       out_valid, busy, done, err};

    int total = 0;
    int bad   = 0;
    int n_ov, n_est, n_dn, n_err, n_act, n_ld, ph_bad, stall_bad;
    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_ov = 0; n_est = 0; n_dn = 0; n_err = 0; n_act = 0;
        n_ld = 0; ph_bad = 0; stall_bad = 0;
    endtask

    // Observe n cycles with the current inputs, accumulating event counts.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
            if (en_stream) n_est++;
            if (done)      n_dn++;
            if (err)       n_err++;
            if ((32'(obs) >> 1) != 0) n_act++;
            if (Ld_data) begin
                if (sel_xi2 != 2'(n_ld % 4)) ph_bad++;
                n_ld++;
            end
            if (!out_ready && (Ld_data || en_sum || Ld_p1_xi)) stall_bad++;
            tick();
        end
    endtask

    task automatic pulse_start(input logic [LW-1:0] len);
        cfg_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        int first_ov;
        int sw_bad;
        rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
        out_ready = 1'b0; in_data = 32'sh1234_5678;
        #2;
        chk("reset_state", 32'(obs), 32'd0);
        chk("reset_passthru", 32'(data_to_process), 32'h1234_5678);
        tick(); tick();
        rst = 1'b0;

        // Basic frame, cfg_len=3, one row per cycle starting at the start cycle
        for (int i = 0; i < 15; i++) begin
            vt[i].st = 1'b0; vt[i].iv = 1'b1; vt[i].ordy = 1'b1;
        end
        vt[0].st = 1'b1;
        vt[0].exp  = 17'b000_0_0_0_0_0_0_00_0_0_0_0_0_0;
        vt[1].exp  = 17'b001_0_0_0_0_0_0_00_0_1_0_1_0_0;
        vt[2].exp  = 17'b010_0_0_0_0_0_0_00_0_1_0_1_0_0;
        vt[3].exp  = 17'b100_0_0_0_0_0_0_00_0_1_0_1_0_0;
        vt[4].exp  = 17'b000_1_1_0_0_0_0_00_0_0_0_1_0_0;
        vt[5].exp  = 17'b000_0_0_0_1_0_0_00_0_0_0_1_0_0;
        vt[6].exp  = 17'b000_0_0_1_0_1_1_00_0_0_0_1_0_0;
        vt[7].exp  = 17'b000_0_0_0_1_0_0_01_0_0_1_1_0_0;
        vt[8].exp  = 17'b000_0_0_1_0_1_1_01_0_0_0_1_0_0;
        vt[9].exp  = 17'b000_0_0_0_1_0_0_10_0_0_1_1_0_0;
        vt[10].exp = 17'b000_0_0_1_0_1_1_10_0_0_0_1_0_0;
        vt[11].exp = 17'b000_0_0_0_1_0_0_11_0_0_1_1_0_0;
        vt[12].exp = 17'b000_0_0_1_0_1_1_11_0_0_0_1_1_0;
        vt[13].exp = 17'b000_0_0_0_0_0_0_00_0_0_1_0_0_0;
        vt[14].exp = 17'b000_0_0_0_0_0_0_00_0_0_0_0_0_0;
        cfg_len = 16'd3;
        for (int i = 0; i < 15; i++) begin
            start = vt[i].st; in_valid = vt[i].iv; out_ready = vt[i].ordy;
            @(negedge clk);
            chk($sformatf("frame3_c%0d", i), 32'(obs), 32'(vt[i].exp));
            tick();
        end

        // cfg_len=5: three segments of four outputs
        clr_counts();
        pulse_start(16'd5);
        run(50);
        chk("len5_outputs", n_ov, 12);
        chk("len5_en_stream", n_est, 2);
        chk("len5_done", n_dn, 1);
        chk("len5_phase_order", ph_bad, 0);
        chk("len5_idle_end", 32'(busy), 0);

        // cfg_len=2 is rejected
        clr_counts();
        pulse_start(16'd2);
        run(6);
        chk("len2_err", n_err, 1);
        chk("len2_no_activity", n_act, 0);

        // Output stall of 5 cycles while in MUL2 (phase 1)
        clr_counts();
        pulse_start(16'd3);
        run(7);
        out_ready = 1'b0;
        run(5);
        chk("stall_strobes", stall_bad, 0);
        chk("stall_busy", 32'(busy), 1);
        out_ready = 1'b1;
        #1;
        chk("stall_resume", {30'd0, Ld_data, sel_xi2 == 2'd1}, 32'd3);
        run(15);
        chk("stall_outputs", n_ov, 4);
        chk("stall_done", n_dn, 1);
        chk("stall_phase_order", ph_bad, 0);

        // Input starvation in SHIFT for 4 cycles, cfg_len=4
        clr_counts();
        in_valid = 1'b1;
        pulse_start(16'd4);
        run(3);
        in_valid = 1'b0;
        first_ov = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (in_ready) begin
                first_ov = k;
                break;
            end
            tick();
        end
        chk("shift_reached", 32'(first_ov >= 0), 1);
        sw_bad = 0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                tick();
                @(negedge clk);
            end
            if (!in_ready || en_stream || !busy || op_1) sw_bad++;
        end
        chk("shift_wait", sw_bad, 0);
        tick();
        in_valid = 1'b1;
        #1;
        chk("shift_accept", {30'd0, en_stream, in_ready}, 32'd3);
        tick();
        chk("shift_to_coef", {30'd0, en_stream, op_1}, 32'd1);
        run(30);
        chk("shift_done", n_dn, 1);
        chk("shift_idle_end", 32'(busy), 0);

        // Asynchronous reset during MUL1 of segment 2
        pulse_start(16'd5);
        for (int k = 1; k < 15; k++) tick();
        @(negedge clk);
        chk("pre_rst_mul1", {29'd0, Ld_p1_xi, sel_xi2}, 32'h4);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'(obs), 32'd0);
        chk("rst_passthru", 32'(data_to_process), 32'h1234_5678);
        tick();
        rst = 1'b0;
        clr_counts();
        run(20);
        chk("rst_no_done", n_dn, 0);
        chk("rst_quiet", n_act, 0);
        pulse_start(16'd3);
        first_ov = -1;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                first_ov = c;
                break;
            end
            tick();
        end
        chk("rst_restart_latency", first_ov, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
